// File: rtl/mmio_bus_bridge.sv
// Registered req/ack bridge from the core data port to NUM_SLV address windows.
// Define MMIO_BUS_TIMEOUT_EN to end an ACCESS with an error after TIMEOUT cycles without ack.
module mmio_bus_bridge #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 3,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE  = {32'h4004, 32'h4000, 32'h0},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_LIMIT = {32'h4100, 32'h4004, 32'h4000},
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_ready,
    output logic                      cpu_err,
    output logic [NUM_SLV-1:0]        slv_sel,
    output logic                      slv_we,
    output logic [ADDR_W-1:0]         slv_addr,
    output logic [DATA_W-1:0]         slv_wdata,
    input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]        slv_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("mmio_bus_bridge: TIMEOUT must be within 2..255");
    end

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                cpu_err_q, cpu_err_d;
    logic [NUM_SLV-1:0]  slv_sel_q, slv_sel_d;
    logic                slv_we_q, slv_we_d;
    logic [ADDR_W-1:0]   slv_addr_q, slv_addr_d;
    logic [DATA_W-1:0]   slv_wdata_q, slv_wdata_d;
`ifdef MMIO_BUS_TIMEOUT_EN
    logic [7:0]          tmo_q, tmo_d;
`endif

    logic [NUM_SLV-1:0]  hit_sel;
    logic [ADDR_W-1:0]   hit_off;
    logic [DATA_W-1:0]   sel_rdata;
    logic                ack_hit;

    // Walk windows from the top index down so the lowest matching index wins.
    always_comb begin
        hit_sel = '0;
        hit_off = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (cpu_addr >= SLV_BASE[i*ADDR_W +: ADDR_W] &&
                cpu_addr <  SLV_LIMIT[i*ADDR_W +: ADDR_W]) begin
                hit_sel = NUM_SLV'(1) << i;
                hit_off = cpu_addr - SLV_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slv_sel_q[i]) sel_rdata |= slv_rdata[i*DATA_W +: DATA_W];
        end
        ack_hit = |(slv_ack & slv_sel_q);
    end

    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        cpu_err_d   = 1'b0;
        slv_sel_d   = slv_sel_q;
        slv_we_d    = slv_we_q;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;
`ifdef MMIO_BUS_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (|hit_sel && cpu_addr[1:0] == 2'b00) begin
                        slv_sel_d   = hit_sel;
                        slv_we_d    = cpu_we;
                        slv_addr_d  = hit_off >> 2;
                        slv_wdata_d = cpu_wdata;
                        state_d     = ACCESS;
`ifdef MMIO_BUS_TIMEOUT_EN
                        tmo_d       = '0;
`endif
                    end else begin
                        cpu_rdata_d = '0;
                        cpu_ready_d = 1'b1;
                        cpu_err_d   = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            ACCESS: begin
                if (ack_hit) begin
                    cpu_rdata_d = slv_we_q ? '0 : sel_rdata;
                    cpu_ready_d = 1'b1;
                    slv_sel_d   = '0;
                    slv_we_d    = 1'b0;
                    state_d     = RESP;
`ifdef MMIO_BUS_TIMEOUT_EN
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    cpu_rdata_d = '0;
                    cpu_ready_d = 1'b1;
                    cpu_err_d   = 1'b1;
                    slv_sel_d   = '0;
                    slv_we_d    = 1'b0;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            slv_sel_q   <= '0;
            slv_we_q    <= 1'b0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
`ifdef MMIO_BUS_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_err_q   <= cpu_err_d;
            slv_sel_q   <= slv_sel_d;
            slv_we_q    <= slv_we_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
`ifdef MMIO_BUS_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_err   = cpu_err_q;
    assign slv_sel   = slv_sel_q;
    assign slv_we    = slv_we_q;
    assign slv_addr  = slv_addr_q;
    assign slv_wdata = slv_wdata_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Directed self-checking bench for mmio_bus_bridge (RAM / PS2 / VRAM default map).
// Covers the MMIO_BUS_TIMEOUT_EN build as well as the default build.
module tb_mmio_bus_bridge;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic [2:0]  slv_sel;
    logic        slv_we;
    logic [31:0] slv_addr;
    logic [31:0] slv_wdata;
    logic [95:0] slv_rdata;
    logic [2:0]  slv_ack;

    int checks;
    int failures;

    mmio_bus_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .slv_sel   (slv_sel),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata),
        .slv_ack   (slv_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        slv_rdata = '0;
        slv_ack   = '0;
        #3;
        checks++;
        if ({cpu_ready, cpu_err, slv_sel, slv_we} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000", {cpu_ready, cpu_err, slv_sel, slv_we});
        end
        tick();
        tick();
        checks++;
        if ({cpu_rdata, slv_addr, slv_wdata} !== 96'h0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h expected 0", {cpu_rdata, slv_addr, slv_wdata});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0010;
        slv_rdata[31:0] = 32'hDEADBEEF;
        tick();
        checks++;
        if (slv_sel !== 3'b001 || slv_addr !== 32'd4 || slv_we !== 1'b0 || cpu_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_access: sel=%b addr=%h we=%b ready=%b expected 001/4/0/0", slv_sel, slv_addr, slv_we, cpu_ready);
        end
        slv_ack = 3'b001;
        tick();
        slv_ack = 3'b000;
        checks++;
        if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'hDEADBEEF || slv_sel !== 3'b000) begin
            failures++;
            $display("[TB] FAIL read_resp: ready=%b err=%b rdata=%h sel=%b expected 1/0/deadbeef/000", cpu_ready, cpu_err, cpu_rdata, slv_sel);
        end
        cpu_req = 1'b0;
        tick();
        checks++;
        if (cpu_ready !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL read_hold: ready=%b rdata=%h expected 0/deadbeef", cpu_ready, cpu_rdata);
        end
    endtask

    task automatic test_unmapped();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_4100;
        tick();
        cpu_req = 1'b0;
        checks++;
        if (cpu_ready !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'h0 || slv_sel !== 3'b000) begin
            failures++;
            $display("[TB] FAIL unmapped_resp: ready=%b err=%b rdata=%h sel=%b expected 1/1/0/000", cpu_ready, cpu_err, cpu_rdata, slv_sel);
        end
        tick();
        checks++;
        if (cpu_ready !== 1'b0 || cpu_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL unmapped_clear: ready=%b err=%b expected 0/0", cpu_ready, cpu_err);
        end
    endtask

    task automatic test_misaligned();
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 32'h0000_0002;
        cpu_wdata = 32'h0000_00AA;
        tick();
        cpu_req = 1'b0;
        checks++;
        if (cpu_ready !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'h0 || slv_sel !== 3'b000 || slv_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL misaligned_resp: ready=%b err=%b rdata=%h sel=%b we=%b expected 1/1/0/000/0", cpu_ready, cpu_err, cpu_rdata, slv_sel, slv_we);
        end
        tick();
    endtask

    task automatic test_write_wait();
        int badCycles;
        badCycles = 0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_4008;
        cpu_wdata = 32'h0000_0012;
        slv_rdata[95:64] = 32'hCAFE_F00D;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (slv_sel !== 3'b100 || slv_we !== 1'b1 || slv_addr !== 32'd1 ||
                slv_wdata !== 32'h12 || cpu_ready !== 1'b0) badCycles++;
            if (c == 2)      slv_ack = 3'b001;
            else if (c == 4) slv_ack = 3'b100;
            else             slv_ack = 3'b000;
            tick();
        end
        slv_ack = 3'b000;
        checks++;
        if (badCycles !== 0) begin
            failures++;
            $display("[TB] FAIL write_hold: got %0d bad cycles expected 0", badCycles);
        end
        checks++;
        if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0 || slv_sel !== 3'b000 || slv_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_resp: ready=%b err=%b rdata=%h sel=%b we=%b expected 1/0/0/000/0", cpu_ready, cpu_err, cpu_rdata, slv_sel, slv_we);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int readyCycle [2];
        logic [31:0] readyData [2];
        int nReady;
        int ps2Starts;
        logic prevPs2;
        nReady    = 0;
        ps2Starts = 0;
        prevPs2   = 1'b0;
        readyCycle[0] = -1;
        readyCycle[1] = -1;
        readyData[0]  = '0;
        readyData[1]  = '0;
        slv_rdata = {32'h0, 32'h0000_0051, 32'hA0A0_A0A0};
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_4000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (slv_sel[1] && !prevPs2) ps2Starts++;
            prevPs2 = slv_sel[1];
            slv_ack = slv_sel;
            if (cpu_ready === 1'b1 && nReady < 2) begin
                readyCycle[nReady] = c;
                readyData[nReady]  = cpu_rdata;
                nReady++;
                cpu_addr = 32'h0000_0000;
                if (nReady == 2) cpu_req = 1'b0;
            end
        end
        slv_ack = 3'b000;
        checks++;
        if (readyCycle[0] !== 2 || readyCycle[1] !== 5) begin
            failures++;
            $display("[TB] FAIL b2b_timing: ready cycles %0d,%0d expected 2,5", readyCycle[0], readyCycle[1]);
        end
        checks++;
        if (readyData[0] !== 32'h51 || readyData[1] !== 32'hA0A0A0A0) begin
            failures++;
            $display("[TB] FAIL b2b_data: got %h,%h expected 00000051,a0a0a0a0", readyData[0], readyData[1]);
        end
        checks++;
        if (ps2Starts !== 1) begin
            failures++;
            $display("[TB] FAIL b2b_ps2_once: got %0d selections expected 1", ps2Starts);
        end
    endtask

`ifdef MMIO_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int selCycles;
        int readyCycle;
        logic errSeen;
        logic [31:0] dataSeen;
        selCycles  = 0;
        readyCycle = -1;
        errSeen    = 1'b0;
        dataSeen   = 32'hFFFF_FFFF;
        slv_ack  = 3'b000;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0000;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (slv_sel === 3'b001) selCycles++;
            if (cpu_ready === 1'b1 && readyCycle < 0) begin
                readyCycle = c;
                errSeen    = cpu_err;
                dataSeen   = cpu_rdata;
                cpu_req    = 1'b0;
            end
        end
        checks++;
        if (selCycles !== 16 || readyCycle !== 17) begin
            failures++;
            $display("[TB] FAIL timeout_timing: sel cycles %0d ready cycle %0d expected 16,17", selCycles, readyCycle);
        end
        checks++;
        if (errSeen !== 1'b1 || dataSeen !== 32'h0) begin
            failures++;
            $display("[TB] FAIL timeout_resp: err=%b rdata=%h expected 1/0", errSeen, dataSeen);
        end
    endtask
`else
    task automatic test_no_timeout();
        int badCycles;
        badCycles = 0;
        slv_ack  = 3'b000;
        slv_rdata[31:0] = 32'h5555_AAAA;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0000;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (slv_sel !== 3'b001 || cpu_ready !== 1'b0) badCycles++;
        end
        checks++;
        if (badCycles !== 0) begin
            failures++;
            $display("[TB] FAIL wait_forever: got %0d bad cycles expected 0", badCycles);
        end
        slv_ack = 3'b001;
        tick();
        slv_ack = 3'b000;
        cpu_req = 1'b0;
        checks++;
        if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h5555AAAA) begin
            failures++;
            $display("[TB] FAIL late_ack_resp: ready=%b err=%b rdata=%h expected 1/0/5555aaaa", cpu_ready, cpu_err, cpu_rdata);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid_access();
        slv_ack  = 3'b000;
        slv_rdata[31:0] = 32'h1357_9BDF;
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 32'h0000_4000;
        cpu_wdata = 32'h0000_0077;
        tick();
        tick();
        checks++;
        if (slv_sel !== 3'b010 || slv_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset_sel: sel=%b we=%b expected 010/1", slv_sel, slv_we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (slv_sel !== 3'b000 || slv_we !== 1'b0 || cpu_ready !== 1'b0 || cpu_err !== 1'b0 || slv_wdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL async_reset: sel=%b we=%b ready=%b err=%b wdata=%h expected 000/0/0/0/0", slv_sel, slv_we, cpu_ready, cpu_err, slv_wdata);
        end
        cpu_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0008;
        tick();
        checks++;
        if (slv_sel !== 3'b001 || slv_addr !== 32'd2) begin
            failures++;
            $display("[TB] FAIL post_reset_access: sel=%b addr=%h expected 001/2", slv_sel, slv_addr);
        end
        slv_ack = 3'b001;
        tick();
        slv_ack = 3'b000;
        cpu_req = 1'b0;
        checks++;
        if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h13579BDF) begin
            failures++;
            $display("[TB] FAIL post_reset_resp: ready=%b err=%b rdata=%h expected 1/0/13579bdf", cpu_ready, cpu_err, cpu_rdata);
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_read();
        test_unmapped();
        test_misaligned();
        test_write_wait();
        test_back_to_back();
`ifdef MMIO_BUS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_bus_bridge.md
Name: mmio_bus_bridge

Overview:
- Registered, handshaked successor to the single-cycle combinational RAM/PS2/VRAM decoder.
- Sits between the ARMv4 core data port and NUM_SLV memory-mapped slaves (RAM, PS/2, VRAM, future peripherals).
- Decodes the address against parametrised base/limit windows and converts byte address to slave word index.
- Drives a req/ack handshake per slave, so slaves may insert wait states; returns ready/err to the core.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address bus width.
- NUM_SLV, 3, number of slave windows.
- SLV_BASE, {32'h4004, 32'h4000, 32'h0}, packed NUM_SLV*ADDR_W inclusive base addresses; slave i occupies slice i.
- SLV_LIMIT, {32'h4100, 32'h4004, 32'h4000}, packed NUM_SLV*ADDR_W exclusive limits.
- TIMEOUT, 16, ACCESS cycles without ack before an error response (range 2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  core access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  error flag, valid while cpu_ready=1.
- slv_sel  out  NUM_SLV  one-hot slave select.
- slv_we  out  1  write strobe qualifier for the selected slave.
- slv_addr  out  ADDR_W  word index: (cpu_addr - base) >> 2.
- slv_wdata  out  DATA_W  write data to slaves.
- slv_rdata  in  NUM_SLV*DATA_W  per-slave read data, slice i.
- slv_ack  in  NUM_SLV  per-slave completion.

Behaviour:
- Reset (async, rst_n=0): state IDLE; cpu_rdata=0, cpu_ready=0, cpu_err=0, slv_sel=0, slv_we=0, slv_addr=0, slv_wdata=0; timeout counter=0. All outputs return to these values immediately when reset is asserted.
- All outputs come from registers; there is no combinational path from any input to any output.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - cpu_req=1 latches we, addr and wdata, then decodes.
  - Hit: lowest index i with SLV_BASE[i] <= addr < SLV_LIMIT[i]. On a hit, load slv_sel[i]=1, slv_we=we, slv_addr and slv_wdata, then go to ACCESS.
  - No hit, or addr[1:0] != 0: no slave selected; go to RESP with err=1 and rdata=0.
- ACCESS:
  - Outputs held stable until slv_ack[i]=1 for the selected i. Acks from unselected slaves are ignored.
  - On ack: capture rdata = we ? 0 : slv_rdata slice i; clear slv_sel and slv_we; go to RESP with err=0.
  - Ack in the first ACCESS cycle is legal.
- RESP: cpu_ready=1 for exactly one cycle with rdata/err, then IDLE. cpu_rdata holds its value until the next RESP; cpu_err clears in IDLE.
- Latency: request seen at edge 0, zero-wait slave acks in cycle 1, cpu_ready in cycle 2. Each slave wait state adds one cycle. Unmapped access gives cpu_ready in cycle 1.
- cpu_req is ignored outside IDLE. Any high cpu_req in IDLE starts a new access, so back-to-back transfers are legal. A core wanting no further access must drop req in the RESP cycle.
- Overlapping windows: the lowest index wins.
- Arithmetic: subtraction is modulo 2^ADDR_W; the shift is logical.
- Reset mid-ACCESS: slave select drops asynchronously. A slave write already committed by its ack edge is not rolled back.

Optional Feature:
- Macro MMIO_BUS_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When it reaches TIMEOUT-1 with no ack, the bridge clears slv_sel and goes to RESP with err=1 and rdata=0. An ack in the same cycle takes priority (normal completion).
- Undefined: no counter; ACCESS waits indefinitely for ack.

Test Plan:
- Read 0x0000_0010, RAM acks in the first ACCESS cycle with 0xDEADBEEF -> slv_sel=3'b001, slv_addr=4; cpu_ready in cycle 2 with rdata 0xDEADBEEF, err=0.
- Write 0x4008 data 0x12, VRAM acks after 3 wait cycles -> slv_sel=3'b100, slv_we=1, slv_addr=1, slv_wdata=0x12 held 4 cycles; cpu_ready in cycle 5, err=0, rdata=0.
- Read 0x4100 (unmapped), then 0x0002 (misaligned) -> no slv_sel; each gives cpu_ready in cycle 1, err=1, rdata=0.
- Back-to-back: req held high for reads to 0x4000 then 0x0 -> two cpu_ready pulses 3 cycles apart; the PS/2 slave (slv_sel=3'b010) is selected exactly once.
- With MMIO_BUS_TIMEOUT_EN and TIMEOUT=16, RAM never acks -> slv_sel high 16 cycles then 0; cpu_ready with err=1 in the next cycle.
- rst_n pulsed low mid-ACCESS -> slv_sel=0 and cpu_ready=0 immediately; after release the next request completes normally.
